ni_tx_packetizer: RTL

Network-interface transmitter that turns a PE-side packet command plus a payload word stream into 34-bit flits for a router local input port. It drives the router's req/ack flit handshake as the upstream sender. It sits between a processing element and router port 4 (local). Outputs are registered; it sustains one flit per cycle when ack is held high.

---
 rtl/ni_tx_packetizer.sv | 119 +++++++++++
 1 files changed

// File: rtl/ni_tx_packetizer.sv
// Network-interface transmitter: turns a packet command plus payload words into
// head/body/tail flits for a router local port using a req/ack handshake.
module ni_tx_packetizer #(
    parameter int SRC_ID  = 1,
    parameter int MAX_LEN = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pkt_valid,
    output logic        pkt_ready,
    input  logic [3:0]  pkt_dst,
    input  logic [7:0]  pkt_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_in,
    output logic [33:0] out_flit,
    output logic        out_req,
    input  logic        in_ack,
    output logic        busy,
    output logic [15:0] pkt_sent
);
    localparam logic [1:0] FT_HEAD   = 2'b10;
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_TAIL   = 2'b01;
    localparam logic [1:0] FT_SINGLE = 2'b11;
    localparam logic [3:0] SRC       = 4'(SRC_ID);
    localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD} state_t;

    state_t      state_reg, state_next;
    logic [33:0] flit_reg, flit_next;
    logic        req_reg, req_next;
    logic [7:0]  len_reg, len_next;
    logic [7:0]  loaded_reg, loaded_next;
    logic [15:0] sent_reg, sent_next;
    logic [7:0]  len_clamped;
    logic        ack;
    logic        load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            flit_reg   <= '0;
            req_reg    <= 1'b0;
            len_reg    <= '0;
            loaded_reg <= '0;
            sent_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            flit_reg   <= flit_next;
            req_reg    <= req_next;
            len_reg    <= len_next;
            loaded_reg <= loaded_next;
            sent_reg   <= sent_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        flit_next   = flit_reg;
        req_next    = req_reg;
        len_next    = len_reg;
        loaded_next = loaded_reg;
        sent_next   = sent_reg;

        len_clamped = ({24'd0, pkt_len} > MAX_LEN) ? LEN_MAX : pkt_len;
        ack         = req_reg && in_ack;
        pkt_ready   = (state_reg == IDLE);
        // A new word may only enter the output register once the current flit leaves it.
        data_ready  = (state_reg != IDLE) && (loaded_reg < len_reg) && (!req_reg || in_ack);
        load        = data_valid && data_ready;

        case (state_reg)
            IDLE: begin
                if (pkt_valid) begin
                    len_next    = len_clamped;
                    loaded_next = '0;
                    flit_next   = {(len_clamped == 8'd0) ? FT_SINGLE : FT_HEAD,
                                   SRC, pkt_dst, len_clamped, 16'h0000};
                    req_next    = 1'b1;
                    state_next  = HEAD;
                end
            end
            HEAD: begin
                if (ack) begin
                    if (len_reg == 8'd0) begin
                        sent_next  = sent_reg + 16'd1;
                        state_next = IDLE;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (ack && flit_reg[33:32] == FT_TAIL) begin
                    sent_next  = sent_reg + 16'd1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A load replaces the acked flit in the same edge; an ack alone leaves a bubble.
        if (load) begin
            flit_next   = {(loaded_reg + 8'd1 == len_reg) ? FT_TAIL : FT_BODY, data_in};
            req_next    = 1'b1;
            loaded_next = loaded_reg + 8'd1;
        end else if (ack) begin
            req_next = 1'b0;
        end
    end

    assign out_flit = flit_reg;
    assign out_req  = req_reg;
    assign busy     = (state_reg != IDLE);
    assign pkt_sent = sent_reg;

endmodule
